// File: rtl/spike_aer_encoder.sv
// Spike vector -> {timestamp, index} address events; 2 cycles spike-to-valid, one event/cycle.
// Full FIFO stalls only the scanner while new spikes keep collecting in pend (repeats are dropped).
module spike_aer_encoder #(
  parameter int N     = 8,
  parameter int IDX_W = 3,
  parameter int TS_W  = 8,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N-1:0]              spike_in,
  input  logic                      aer_ready,
  output logic                      aer_valid,
  output logic [TS_W+IDX_W-1:0]     aer_data,
  output logic [$clog2(DEPTH):0]    fifo_cnt,
  output logic [7:0]                drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = TS_W + IDX_W;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state_q, state_d;
  logic [TS_W-1:0]   ts_q, scan_ts_q, scan_ts_d;
  logic [N-1:0]      pend_q, pend_d, scan_vec_q, scan_vec_d;
  logic [N-1:0]      any_in, sel_oh, coll;
  logic [7:0]        drop_q, drop_d;
  logic [IDX_W-1:0]  sel;
  logic [IDX_W:0]    coll_cnt;
  logic [8:0]        drop_sum;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [PW:0]       cnt_q, cnt_d;
  logic              push, pop, push_ok;

  assign aer_valid = (cnt_q != '0);
  assign aer_data  = aer_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_cnt  = cnt_q;
  assign drop_cnt  = drop_q;

  assign pop     = aer_valid & aer_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok = (cnt_q != FULL) | pop;
  assign any_in  = spike_in | pend_q;
  assign sel_oh  = scan_vec_q & (~scan_vec_q + N'(1));
  assign coll    = spike_in & pend_q;

  always_comb begin
    sel      = '0;
    coll_cnt = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (scan_vec_q[i]) sel = IDX_W'(i);
    end
    for (int i = 0; i < N; i++) begin
      coll_cnt = coll_cnt + {{IDX_W{1'b0}}, coll[i]};
    end
    drop_sum = {1'b0, drop_q} + 9'(coll_cnt);
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    scan_vec_d = scan_vec_q;
    scan_ts_d  = scan_ts_q;
    drop_d     = drop_q;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_in != '0) begin
          scan_vec_d = any_in;
          scan_ts_d  = ts_q;
          pend_d     = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        pend_d = pend_q | spike_in;
        drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        if (push_ok) begin
          push       = 1'b1;
          scan_vec_d = scan_vec_q & ~sel_oh;
          if ((scan_vec_q & ~sel_oh) == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + (PW+1)'(1);
    else if (!push && pop) cnt_d = cnt_q - (PW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ts_q       <= '0;
      pend_q     <= '0;
      scan_vec_q <= '0;
      scan_ts_q  <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_q + TS_W'(1);
      pend_q     <= pend_d;
      scan_vec_q <= scan_vec_d;
      scan_ts_q  <= scan_ts_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {scan_ts_q, sel};
  end

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder; ts_now tracks the value the DUT timestamp holds after each edge.
module tb_spike_aer_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  spike_in;
  logic        aer_ready;
  logic        aer_valid;
  logic [10:0] aer_data;
  logic [3:0]  fifo_cnt;
  logic [7:0]  drop_cnt;

  int n_err    = 0;
  int n_checks = 0;
  logic [7:0] ts_now = 8'd0;
  logic [7:0] ts_a, ts_b, ts_c, ts_d, ts_f;

  always #5 clk = ~clk;

  spike_aer_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .spike_in  (spike_in),
    .aer_ready (aer_ready),
    .aer_valid (aer_valid),
    .aer_data  (aer_data),
    .fifo_cnt  (fifo_cnt),
    .drop_cnt  (drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    if (reset) ts_now = 8'd0;
    else       ts_now = ts_now + 8'd1;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ev(input logic [7:0] ts, input logic [2:0] idx);
    return {21'd0, ts, idx};
  endfunction

  // Waits (bounded) for the next event, checks it, then pops it with a one-cycle ready pulse.
  task automatic next_ev(input string tag, input logic [31:0] exp);
    for (int i = 0; i < 20 && !aer_valid; i++) tick();
    check({tag, "_valid"}, 32'(aer_valid), 32'd1);
    check({tag, "_data"}, 32'(aer_data), exp);
    aer_ready = 1'b1;
    tick();
    aer_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; spike_in = 8'h00; aer_ready = 1'b1;
    tick(); tick();
    check("rst_valid", 32'(aer_valid), 32'd0);
    check("rst_data",  32'(aer_data),  32'd0);
    check("rst_cnt",   32'(fifo_cnt),  32'd0);
    check("rst_drop",  32'(drop_cnt),  32'd0);

    // 1: single spike at ts=5
    reset = 1'b0;
    repeat (5) tick();
    spike_in = 8'h01; tick(); spike_in = 8'h00;
    check("t1_valid_1cyc", 32'(aer_valid), 32'd0);
    tick();
    check("t1_valid_2cyc", 32'(aer_valid), 32'd1);
    check("t1_data", 32'(aer_data), ev(8'd5, 3'd0));
    check("t1_cnt",  32'(fifo_cnt), 32'd1);
    tick();
    check("t1_empty", 32'(aer_valid), 32'd0);
    check("t1_cnt0",  32'(fifo_cnt),  32'd0);
    check("t1_drop",  32'(drop_cnt),  32'd0);

    // 2: A5 -> idx 0,2,5,7 on consecutive cycles, one timestamp
    ts_a = ts_now;
    spike_in = 8'hA5; tick(); spike_in = 8'h00;
    tick(); check("t2_ev0", 32'(aer_data), ev(ts_a, 3'd0));
    tick(); check("t2_ev2", 32'(aer_data), ev(ts_a, 3'd2));
    tick(); check("t2_ev5", 32'(aer_data), ev(ts_a, 3'd5));
    tick(); check("t2_ev7", 32'(aer_data), ev(ts_a, 3'd7));
    tick(); check("t2_done", 32'(aer_valid), 32'd0);

    // 3: FF with sink blocked fills the FIFO
    aer_ready = 1'b0;
    ts_b = ts_now;
    spike_in = 8'hFF; tick(); spike_in = 8'h00;
    repeat (8) tick();
    check("t3_full",  32'(fifo_cnt), 32'd8);
    check("t3_drop",  32'(drop_cnt), 32'd0);
    check("t3_head",  32'(aer_data), ev(ts_b, 3'd0));

    // 4: stalled scan of idx4; idx1 fires twice while held in pend -> one drop
    ts_c = ts_now;
    spike_in = 8'h10; tick();
    spike_in = 8'h02; tick();
    spike_in = 8'h00; tick();
    spike_in = 8'h02; tick();
    spike_in = 8'h00;
    check("t4_drop1", 32'(drop_cnt), 32'd1);
    tick(); tick();
    check("t4_stall_cnt", 32'(fifo_cnt), 32'd8);
    check("t4_stable",    32'(aer_data), ev(ts_b, 3'd0));
    aer_ready = 1'b1;
    tick();
    ts_d = ts_now;
    for (int k = 1; k < 8; k++) begin
      check($sformatf("t3_drain%0d", k), 32'(aer_data), ev(ts_b, 3'(k)));
      tick();
    end
    check("t4_ev_idx4", 32'(aer_data), ev(ts_c, 3'd4));
    tick();
    check("t4_ev_idx1", 32'(aer_data), ev(ts_d, 3'd1));
    tick();
    check("t4_empty", 32'(aer_valid), 32'd0);
    check("t4_cnt0",  32'(fifo_cnt),  32'd0);

    // 4b: continuous FF with sink blocked: 7 colliding edges (+56), then saturation
    aer_ready = 1'b0;
    spike_in = 8'hFF; tick();
    repeat (8) tick();
    check("t4_drop57", 32'(drop_cnt), 32'd57);
    repeat (37) tick();
    check("t4_sat",    32'(drop_cnt), 32'd255);
    repeat (3) tick();
    check("t4_sat_hold", 32'(drop_cnt), 32'd255);
    check("t4_sat_cnt",  32'(fifo_cnt), 32'd8);
    spike_in = 8'h00; aer_ready = 1'b1;
    repeat (40) tick();
    check("t4_flush_valid", 32'(aer_valid), 32'd0);
    check("t4_flush_cnt",   32'(fifo_cnt),  32'd0);

    // 5: spikes at ts 254, 255, 0; the ts=255 spike waits in pend and is captured at ts=0
    aer_ready = 1'b0;
    for (int i = 0; i < 300 && ts_now != 8'd254; i++) tick();
    spike_in = 8'h40; tick();
    spike_in = 8'h08; tick();
    spike_in = 8'h01; tick();
    spike_in = 8'h00;
    next_ev("t5_ts254", ev(8'd254, 3'd6));
    next_ev("t5_ts0a",  ev(8'd0,   3'd0));
    next_ev("t5_ts0b",  ev(8'd0,   3'd3));

    // 6: reset with four events still buffered
    ts_f = ts_now;
    spike_in = 8'hF8; tick(); spike_in = 8'h00;
    repeat (5) tick();
    check("t6_cnt5", 32'(fifo_cnt), 32'd5);
    aer_ready = 1'b1; tick();
    check("t6_cnt4", 32'(fifo_cnt), 32'd4);
    check("t6_head", 32'(aer_data), ev(ts_f, 3'd4));
    reset = 1'b1; tick();
    check("t6_valid", 32'(aer_valid), 32'd0);
    check("t6_cnt",   32'(fifo_cnt),  32'd0);
    check("t6_drop",  32'(drop_cnt),  32'd0);
    check("t6_data",  32'(aer_data),  32'd0);
    reset = 1'b0; aer_ready = 1'b0;
    tick(); tick();
    check("t6_quiet", 32'(aer_valid), 32'd0);
    spike_in = 8'h01; tick(); spike_in = 8'h00;
    next_ev("t6_ts2", ev(8'd2, 3'd0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
